// File: rtl/trading_pkg.sv
// Shared types and constants for the order return path.
// Side encoding, ASCII bytes, message length, FSM states.
package trading_pkg;

  typedef enum logic [1:0] {
    SIDE_NONE = 2'b00,
    SIDE_BUY  = 2'b01,
    SIDE_SELL = 2'b10
  } side_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_CONV,
    ST_SEND,
    ST_WAIT
  } state_t;

  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int MSG_LEN = 7;

  function automatic side_t calc_side(
    input logic [15:0] p,
    input logic [15:0] t
  );
    side_t s;
    s = SIDE_NONE;
    if (p < t) s = SIDE_BUY;
    else if (p > t) s = SIDE_SELL;
    return s;
  endfunction

  // Double-dabble correction applied before each shift.
  function automatic logic [19:0] bcd_adjust(
    input logic [19:0] b
  );
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start, 8 data LSB first, stop.
// Ports: data_in/load accepted when ready; tx idles high.
module uart_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       ready,
  output logic       tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BAUD_DIV + 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          active;
  logic          bit_end;

  assign bit_end = active &&
    (baud_cnt == CW'(BAUD_DIV - 1));

  // Ready already in the last cycle of the stop bit
  // so the next frame can follow with a minimal gap.
  assign ready = ~active |
    (bit_end && bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (load && ready) begin
      tx       <= 1'b0;
      shreg    <= {1'b1, data_in};
      bit_cnt  <= '0;
      baud_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b0, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/order_tx.sv
// Re-derives BUY/SELL per price; on side change sends "Xddddd\n".
// Ports: price/threshold/new_price in; tx, busy, stats out.
import trading_pkg::*;

module order_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] price,
  input  logic [15:0] threshold,
  input  logic        new_price,
  output logic        tx,
  output logic        busy,
  output logic [1:0]  last_side,
  output logic [15:0] order_count,
  output logic [7:0]  overrun
);

  state_t      state;
  side_t       side_q;
  side_t       last_q;
  side_t       eval_side;
  logic [15:0] cur_price;
  logic [15:0] cur_thr;
  logic [15:0] slot_price;
  logic [15:0] slot_thr;
  logic        slot_full;
  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  iter;
  logic [2:0]  idx;
  logic [7:0]  data_q;
  logic [7:0]  msg_byte;
  logic        load_q;
  logic        ready;

  assign eval_side = calc_side(cur_price, cur_thr);
  assign last_side = last_q;

  always_comb begin
    msg_byte = ASCII_LF;
    case (idx)
      3'd0: msg_byte = (side_q == SIDE_SELL) ?
                       ASCII_S : ASCII_B;
      3'd1: msg_byte = ASCII_0 + {4'd0, bcd_q[19:16]};
      3'd2: msg_byte = ASCII_0 + {4'd0, bcd_q[15:12]};
      3'd3: msg_byte = ASCII_0 + {4'd0, bcd_q[11:8]};
      3'd4: msg_byte = ASCII_0 + {4'd0, bcd_q[7:4]};
      3'd5: msg_byte = ASCII_0 + {4'd0, bcd_q[3:0]};
      default: msg_byte = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      side_q      <= SIDE_NONE;
      last_q      <= SIDE_NONE;
      cur_price   <= '0;
      cur_thr     <= '0;
      slot_price  <= '0;
      slot_thr    <= '0;
      slot_full   <= 1'b0;
      bin_q       <= '0;
      bcd_q       <= '0;
      iter        <= '0;
      idx         <= '0;
      data_q      <= '0;
      load_q      <= 1'b0;
      busy        <= 1'b0;
      order_count <= '0;
      overrun     <= '0;
    end else begin
      // A fresh event landing on a full slot loses the
      // older one, whether we are busy or just idle.
      if (new_price && slot_full && overrun != 8'hFF)
        overrun <= overrun + 8'd1;
      if (new_price && state != ST_IDLE) begin
        slot_price <= price;
        slot_thr   <= threshold;
        slot_full  <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (new_price) begin
            cur_price <= price;
            cur_thr   <= threshold;
            slot_full <= 1'b0;
            state     <= ST_EVAL;
          end else if (slot_full) begin
            cur_price <= slot_price;
            cur_thr   <= slot_thr;
            slot_full <= 1'b0;
            state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (eval_side != SIDE_NONE &&
              eval_side != last_q) begin
            side_q <= eval_side;
            busy   <= 1'b1;
            bin_q  <= cur_price;
            bcd_q  <= '0;
            iter   <= '0;
            state  <= ST_CONV;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CONV: begin
          {bcd_q, bin_q} <=
            {bcd_adjust(bcd_q), bin_q} << 1;
          iter <= iter + 4'd1;
          if (iter == 4'd15) begin
            idx   <= '0;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          data_q <= msg_byte;
          load_q <= 1'b1;
          if (idx == 3'd0) last_q <= side_q;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // First cycle: uart is still taking the load.
          if (load_q) begin
            load_q <= 1'b0;
          end else if (ready) begin
            if (idx == 3'(MSG_LEN - 1)) begin
              busy        <= 1'b0;
              order_count <= order_count + 16'd1;
              state       <= ST_IDLE;
            end else begin
              idx   <= idx + 3'd1;
              state <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_q),
    .load   (load_q),
    .ready  (ready),
    .tx     (tx)
  );

endmodule

// File: tb/tb_order_tx.sv
// Directed bench for order_tx: vector table plus
// overrun, latency, reset-abort and slow-baud sequences.
module tb_order_tx;

  localparam int D = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] price;
  logic [15:0] threshold;
  logic        new_price;
  logic        tx;
  logic        busy;
  logic [1:0]  last_side;
  logic [15:0] order_count;
  logic [7:0]  overrun;

  logic        s_new_price;
  logic        s_tx;
  logic        s_busy;
  logic [1:0]  s_last_side;
  logic [15:0] s_order_count;
  logic [7:0]  s_overrun;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  order_tx #(
    .CLK_FREQ (50000000),
    .BAUD_RATE(5000000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .price      (price),
    .threshold  (threshold),
    .new_price  (new_price),
    .tx         (tx),
    .busy       (busy),
    .last_side  (last_side),
    .order_count(order_count),
    .overrun    (overrun)
  );

  order_tx #(
    .CLK_FREQ (50000000),
    .BAUD_RATE(9600)
  ) dut_slow (
    .clk        (clk),
    .rst        (rst),
    .price      (price),
    .threshold  (threshold),
    .new_price  (s_new_price),
    .tx         (s_tx),
    .busy       (s_busy),
    .last_side  (s_last_side),
    .order_count(s_order_count),
    .overrun    (s_overrun)
  );

  typedef struct packed {
    logic [15:0] price;
    logic [15:0] thr;
    logic        order;
    logic [55:0] msg;
    logic [1:0]  side;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] p,
                       input logic [15:0] t);
    @(negedge clk);
    price     = p;
    threshold = t;
    new_price = 1'b1;
    @(posedge clk);
    #1 new_price = 1'b0;
  endtask

  task automatic recv(output logic [7:0] b,
                      output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    b  = '0;
    while (tx !== 1'b0) begin
      if (t >= 2000) return;
      @(posedge clk);
      #1 t++;
    end
    repeat (D / 2) @(posedge clk);
    #1;
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (D) @(posedge clk);
      #1 b[i] = tx;
    end
    repeat (D) @(posedge clk);
    #1;
    if (tx !== 1'b1) return;
    ok = 1'b1;
  endtask

  task automatic recv_msg(input string nm,
                          input logic [55:0] exp);
    logic [55:0] got;
    logic [7:0]  b;
    bit          ok;
    got = '0;
    for (int i = 0; i < 7; i++) begin
      recv(b, ok);
      if (!ok) begin
        chk({nm, "_frame"}, i, 7);
        return;
      end
      got[55 - 8*i -: 8] = b;
    end
    chk(nm, got, exp);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy === 1'b1 && t < 100) begin
      @(posedge clk);
      #1 t++;
    end
    if (t >= 100) chk({nm, "_idle_timeout"}, t, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit");
    $fatal(1);
  end

  initial begin
    int act;
    int ts;
    int te;
    int w;

    vecs[0] = '{16'd1234, 16'd2000, 1'b1,
                56'h42_30_31_32_33_34_0A,
                2'b01, 16'd1};
    vecs[1] = '{16'd1500, 16'd2000, 1'b0,
                56'h0, 2'b01, 16'd1};
    vecs[2] = '{16'd2000, 16'd2000, 1'b0,
                56'h0, 2'b01, 16'd1};
    vecs[3] = '{16'd65535, 16'd0, 1'b1,
                56'h53_36_35_35_33_35_0A,
                2'b10, 16'd2};
    vecs[4] = '{16'd0, 16'd1, 1'b1,
                56'h42_30_30_30_30_30_0A,
                2'b01, 16'd3};
    vecs[5] = '{16'd7, 16'd7, 1'b0,
                56'h0, 2'b01, 16'd3};

    rst         = 1'b0;
    price       = '0;
    threshold   = '0;
    new_price   = 1'b0;
    s_new_price = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_last_side", last_side, 0);
    chk("rst_order_count", order_count, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;

    // Slow instance: start bit width at 9600 baud.
    // 'S' has data bit 0 high, so the low run is
    // exactly the start bit.
    @(negedge clk);
    price       = 16'd65535;
    threshold   = 16'd0;
    s_new_price = 1'b1;
    @(posedge clk);
    #1 s_new_price = 1'b0;
    ts = 0;
    while (s_tx !== 1'b0 && ts < 200) begin
      @(posedge clk);
      #1 ts++;
    end
    chk("slow_start_seen", ts < 200, 1);
    w = 0;
    while (s_tx === 1'b0 && w < 6000) begin
      @(posedge clk);
      #1 w++;
    end
    chk("slow_start_width", w, 5208);

    // Table of single events.
    for (int i = 0; i < 6; i++) begin
      pulse(vecs[i].price, vecs[i].thr);
      @(posedge clk);
      #1 chk($sformatf("v%0d_busy_c1", i),
             busy, vecs[i].order);
      if (vecs[i].order) begin
        recv_msg($sformatf("v%0d_msg", i),
                 vecs[i].msg);
        wait_idle($sformatf("v%0d", i));
      end else begin
        act = 0;
        repeat (40) begin
          @(posedge clk);
          #1 if (busy !== 1'b0 || tx !== 1'b1)
            act = 1;
        end
        chk($sformatf("v%0d_quiet", i), act, 0);
      end
      chk($sformatf("v%0d_last_side", i),
          last_side, vecs[i].side);
      chk($sformatf("v%0d_order_count", i),
          order_count, vecs[i].cnt);
    end
    chk("table_overrun", overrun, 0);

    // Three events during a message: only the last
    // survives in the slot, two overwrites counted.
    pulse(16'd49876, 16'd100);
    fork
      begin
        recv_msg("ovr_msg1",
                 56'h53_34_39_38_37_36_0A);
        recv_msg("ovr_msg2",
                 56'h42_30_30_30_30_35_0A);
      end
      begin
        repeat (50) @(posedge clk);
        pulse(16'd100, 16'd2000);
        repeat (50) @(posedge clk);
        pulse(16'd3000, 16'd2000);
        repeat (50) @(posedge clk);
        pulse(16'd5, 16'd2000);
      end
    join
    wait_idle("ovr");
    chk("ovr_overrun", overrun, 2);
    chk("ovr_order_count", order_count, 5);
    chk("ovr_last_side", last_side, 1);

    // Latency: start bit at edge 19, busy fall
    // within 19 + 70*D + 12 edges.
    pulse(16'd500, 16'd100);
    ts = -1;
    te = -1;
    for (int k = 1; k <= 1500; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk("lat_busy_c1", busy, 1);
      if (tx === 1'b0 && ts < 0) ts = k;
      if (busy !== 1'b1) begin
        te = k;
        break;
      end
    end
    chk("lat_start_edge", ts, 19);
    chk("lat_busy_fall_ok",
        (te >= 19 + 70*D && te <= 19 + 70*D + 12), 1);
    chk("lat_order_count", order_count, 6);
    chk("lat_last_side", last_side, 2);

    // Asynchronous reset during byte 3's start bit.
    pulse(16'd777, 16'd2000);
    repeat (330) @(posedge clk);
    #2;
    chk("abort_tx_low_before", tx, 0);
    rst = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_last_side", last_side, 0);
    chk("abort_order_count", order_count, 0);
    chk("abort_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulse(16'd1234, 16'd2000);
    recv_msg("post_rst_msg",
             56'h42_30_31_32_33_34_0A);
    wait_idle("post_rst");
    chk("post_rst_order_count", order_count, 1);
    chk("post_rst_last_side", last_side, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
